// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS control path: opcodes, funct
// fields, alu_op selector values and the 4-bit ALU operation codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [3:0] ALUC_AND     = 4'b0000;
    localparam logic [3:0] ALUC_OR      = 4'b0001;
    localparam logic [3:0] ALUC_ADD     = 4'b0010;
    localparam logic [3:0] ALUC_SUB     = 4'b0110;
    localparam logic [3:0] ALUC_SLT     = 4'b0111;
    localparam logic [3:0] ALUC_NOR     = 4'b1100;
    localparam logic [3:0] ALUC_INVALID = 4'b1111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps (alu_op, funct) to the 4-bit ALU operation code; also used standalone
// by the ALU bench.
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        unique case (alu_op)
            ALUOP_ADD:  alu_control = ALUC_ADD;
            ALUOP_SUB:  alu_control = ALUC_SUB;
            ALUOP_ADD2: alu_control = ALUC_ADD;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    FUNCT_NOR: alu_control = ALUC_NOR;
                    default:   alu_control = ALUC_INVALID;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_unit.sv
// Main opcode decode, branch-target adder and program counter for the
// single-cycle MIPS datapath.
module mips_ctrl_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic        zero_flag,
    output logic [1:0]  reg_dst,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_control,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target
);

    logic [31:0] pc_q;
    logic [31:0] imm_off;
    logic [31:0] pc_next;
    logic        take;

    always_comb begin
        reg_dst    = 2'b00;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_ctrl_decode u_alu_ctrl (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

    // Word offset: sign-extend then scale by 4; adds wrap modulo 2^32.
    assign imm_off       = {{14{imm[15]}}, imm, 2'b00};
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + imm_off;
    assign take          = branch & zero_flag;
    assign pc_next       = take ? branch_target : pc_plus4;
    assign pc_out        = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_next;
    end

endmodule

// File: tb/tb_mips_ctrl_unit.sv
// Self-checking bench for mips_ctrl_unit: decode/ALU-control vector table plus
// hand-written PC sequences, all checked through an expected-value queue.
module tb_mips_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        zero_flag;
    logic [1:0]  reg_dst;
    logic        branch, mem_read, mem_write, alu_src, reg_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;
    logic [31:0] pc_out, pc_plus4, branch_target;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    mips_ctrl_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .imm           (imm),
        .zero_flag     (zero_flag),
        .reg_dst       (reg_dst),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .alu_src       (alu_src),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .alu_control   (alu_control),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    typedef struct {
        string       name;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [14:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    // Packed order: reg_dst, branch, mem_read, mem_write, alu_src, reg_write,
    // mem_to_reg, alu_op, alu_control.
    function automatic logic [14:0] mk(logic [1:0] rd, logic br, logic mr, logic mw,
                                       logic as, logic rw, logic [1:0] m2r,
                                       logic [1:0] aop, logic [3:0] aluc);
        return {rd, br, mr, mw, as, rw, m2r, aop, aluc};
    endfunction

    function automatic logic [31:0] ctrl_word();
        return {17'd0, reg_dst, branch, mem_read, mem_write, alu_src, reg_write,
                mem_to_reg, alu_op, alu_control};
    endfunction

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic check_pop(input logic [31:0] actual);
        logic [31:0] e;
        string       nm;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty actual=%h", actual);
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (actual !== e) begin
            n_miss++;
            $display("FAIL %s actual=%h expected=%h", nm, actual, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"rtype_add", 6'b000000, 6'b100000, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b0010)});
        vecs.push_back('{"rtype_sub", 6'b000000, 6'b100010, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b0110)});
        vecs.push_back('{"rtype_and", 6'b000000, 6'b100100, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b0000)});
        vecs.push_back('{"rtype_or",  6'b000000, 6'b100101, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b0001)});
        vecs.push_back('{"rtype_slt", 6'b000000, 6'b101010, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b0111)});
        vecs.push_back('{"rtype_nor", 6'b000000, 6'b100111, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b1100)});
        vecs.push_back('{"rtype_bad", 6'b000000, 6'b000000, mk(2'b01,0,0,0,0,1,2'b00,2'b10,4'b1111)});
        vecs.push_back('{"lw",        6'b100011, 6'b101010, mk(2'b00,0,1,0,1,1,2'b01,2'b00,4'b0010)});
        vecs.push_back('{"sw",        6'b101011, 6'b100111, mk(2'b00,0,0,1,1,0,2'b00,2'b00,4'b0010)});
        vecs.push_back('{"beq_and",   6'b000100, 6'b100100, mk(2'b00,1,0,0,0,0,2'b00,2'b01,4'b0110)});
        vecs.push_back('{"beq_bad",   6'b000100, 6'b111111, mk(2'b00,1,0,0,0,0,2'b00,2'b01,4'b0110)});
        vecs.push_back('{"addi",      6'b001000, 6'b100010, mk(2'b00,0,0,0,1,1,2'b00,2'b00,4'b0010)});
        vecs.push_back('{"nop_3f",    6'b111111, 6'b100000, mk(2'b00,0,0,0,0,0,2'b00,2'b00,4'b0010)});
        vecs.push_back('{"nop_02",    6'b000010, 6'b100010, mk(2'b00,0,0,0,0,0,2'b00,2'b00,4'b0010)});

        reset     = 1'b1;
        opcode    = 6'b111111;
        funct     = 6'b000000;
        imm       = 16'h0000;
        zero_flag = 1'b0;

        // Decode is combinational and follows inputs even while in reset.
        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].opcode;
            funct  = vecs[i].funct;
            expect_val(vecs[i].name, {17'd0, vecs[i].ctrl});
            #1;
            check_pop(ctrl_word());
        end

        opcode = 6'b111111;
        tick();
        expect_val("reset_pc", 32'h0000_0000);      check_pop(pc_out);
        expect_val("reset_pc_plus4", 32'h0000_0004); check_pop(pc_plus4);
        tick();
        expect_val("reset_holds_pc", 32'h0000_0000); check_pop(pc_out);

        @(negedge clk);
        reset = 1'b0;
        tick();
        expect_val("first_after_reset", 32'h0000_0004); check_pop(pc_out);

        // pc 4 -> 0x40 via taken beq (8 + 14*4).
        opcode = 6'b000100; imm = 16'h000E; zero_flag = 1'b1;
        tick();
        expect_val("branch_to_40", 32'h0000_0040); check_pop(pc_out);

        // Asynchronous reset away from any clock edge.
        opcode = 6'b111111; zero_flag = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        expect_val("async_reset_pc", 32'h0000_0000); check_pop(pc_out);
        @(negedge clk);
        reset = 1'b0;
        tick();
        expect_val("release_plus4", 32'h0000_0004); check_pop(pc_out);

        // pc 4 -> 0x100 (8 + 62*4).
        opcode = 6'b000100; imm = 16'h003E; zero_flag = 1'b1;
        tick();
        expect_val("branch_to_100", 32'h0000_0100); check_pop(pc_out);

        imm = 16'h0003;
        #1;
        expect_val("target_pos", 32'h0000_0110); check_pop(branch_target);
        tick();
        expect_val("taken_pc", 32'h0000_0110); check_pop(pc_out);

        // 0x114 - 5*4 = 0x100
        imm = 16'hFFFB;
        tick();
        expect_val("back_to_100", 32'h0000_0100); check_pop(pc_out);

        imm = 16'hFFFF; zero_flag = 1'b0;
        #1;
        expect_val("target_neg", 32'h0000_0100); check_pop(branch_target);
        tick();
        expect_val("not_taken_pc", 32'h0000_0104); check_pop(pc_out);

        opcode = 6'b000000; funct = 6'b100000; imm = 16'h0010; zero_flag = 1'b1;
        tick();
        expect_val("zero_ignored_nonbranch", 32'h0000_0108); check_pop(pc_out);

        // 0x10C + sext(0xFFBC)<<2 = 0xFFFF_FFFC
        opcode = 6'b000100; imm = 16'hFFBC; zero_flag = 1'b1;
        tick();
        expect_val("branch_to_top", 32'hFFFF_FFFC); check_pop(pc_out);
        expect_val("plus4_wrap", 32'h0000_0000);    check_pop(pc_plus4);

        opcode = 6'b000000; funct = 6'b100010; zero_flag = 1'b0;
        tick();
        expect_val("pc_wrap", 32'h0000_0000); check_pop(pc_out);

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
